mem_block_arbiter: RTL
======================

// Module: mem_block_arbiter
// PURPOSE
//  - Shares the single block port of data_memory between NUM_REQ cache requesters: round-robin grant, fixed access latency.
//  - Each requester asks for one block read (refill) or one block write (writeback) per transaction.
//  - Only this block drives the memory write port. It also owns one read port (ptr_out1/out_block1).
// PARAMETERS
//  NUM_REQ   3                        number of requesters (2..4)
//  LATENCY   4                        memory cycles per transaction (>=1), models DRAM delay
//  BLOCK_W   BLOCK_SIZE*WORD_SIZE     block width in bits (512 with parameters.v defaults)
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst            in   1                 asynchronous, active-high reset
//  req            in   NUM_REQ           per-requester request, held until ack
//  req_we         in   NUM_REQ           1 = block write, 0 = block read; valid with req
//  req_addr       in   NUM_REQ*32        byte/word ptr per requester, slice i = [32*i+:32]
//  req_wdata      in   NUM_REQ*BLOCK_W   write block per requester, slice i = [BLOCK_W*i+:BLOCK_W]
//  ack            out  NUM_REQ           one-cycle completion pulse to the granted requester
//  rdata          out  BLOCK_W           read block, valid in the ack cycle, held until the next read completes
//  busy           out  1                 high in BUSY and RESP
//  mem_ptr        out  32                block-aligned ptr {addr[31:4],4'b0}, shared by read and write
//  mem_in_block   out  BLOCK_W           write data to data_memory
//  mem_we         out  1                 write_enable to data_memory
//  mem_out_block  in   BLOCK_W           combinational read block from data_memory
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, ack=0, mem_we=0, busy=0, rdata=0, mem_ptr=0, mem_in_block=0, cnt=0.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE, any req:
//    - Pick grant g as the first set req at or after rr_ptr, wrapping modulo NUM_REQ.
//    - Latch g, we, the aligned addr and wdata. cnt<=LATENCY-1. Go to BUSY.
//  - BUSY, cnt!=0: cnt<=cnt-1. mem_we=0.
//  - BUSY, cnt==0 (final cycle):
//    - Write: mem_we=1 for exactly this cycle.
//    - Read: rdata<=mem_out_block at this edge.
//    - Go to RESP.
//  - RESP: ack[g]=1 for one cycle, rr_ptr<=(g+1)%NUM_REQ, go to IDLE.
//  - Latency: req sampled in IDLE at edge T -> ack high in cycle T+LATENCY+1. No back-to-back grants; min 1 IDLE cycle between transactions.
//  - Handshake:
//    - Requester must hold req, we, addr and wdata stable until ack.
//    - A req still high in the IDLE cycle after ack is a new request.
//  - req dropped mid-transaction: the transaction still completes, the write still happens, and ack still pulses.
//  - Late request: a req arriving in BUSY or RESP waits. Fairness: each active requester is served within NUM_REQ transactions.
//  - mem_ptr, mem_in_block: driven from the latched values for the whole of BUSY. A write never uses unlatched inputs.
//  - Address: addr[3:0] is ignored. The ptr is 32-bit word-indexed, the same convention as data_memory.
//  - Reset mid-transaction:
//    - The transaction is abandoned: no write, no ack, rdata cleared.
//    - Requesters must re-issue.
//  - Invalid inputs: mem_we never asserts outside BUSY. ack is one-hot or zero.
// CONFIGURATION
//  - MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is held at 0. Starvation is permitted.
//  - MEM_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// STRUCTURE
//  - Shared constants go in parameters.v alongside WORD_SIZE, BLOCK_SIZE and MEM_SIZE:
//    - state encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RESP=2'd2
//    - MEM_LATENCY default
//  - One sub-module, rr_arbiter: combinational grant from (req, rr_ptr). It contains the fixed-priority variant under the macro.
//  - FSM, latches and counter live in mem_block_arbiter.
// TESTING
//  1. Reset, then a single read:
//     - Stimulus: req=3'b001, we=0, addr=32'h0000_0013, LATENCY=4, memory words 0x10..0x1F preloaded.
//     - Response: mem_ptr=32'h10 during BUSY; ack=3'b001 exactly 5 cycles after the sampling edge; rdata = the 16 words.
//  2. Write then read back:
//     - Stimulus: req[1] writes 0xA5A5_0000+i to block 0x20, then req[1] reads 0x2C.
//     - Response: mem_we high for exactly 1 cycle; the read returns the written block.
//  3. Round-robin:
//     - Stimulus: req=3'b111 held, each requester re-requests right after its ack.
//     - Response: ack order 001,010,100,001. Under MEM_ARB_FIXED_PRIO_EN, 001 repeats.
//  4. Dropped request:
//     - Stimulus: req[2] write deasserted 1 cycle after grant.
//     - Response: the write still occurs and ack[2] still pulses. The next grant follows the rr order.
//  5. Reset mid-write:
//     - Stimulus: assert rst in BUSY with cnt=2.
//     - Response: outputs at reset values immediately, memory block unchanged, no ack.
//  6. LATENCY=1:
//     - Stimulus: two requesters active, with LATENCY=1.
//     - Response: ack 2 cycles after the sampling edge. Transactions are 3 cycles apart (IDLE, BUSY, RESP).

Source files
------------

// File: rtl/mem_block_arbiter_pkg.sv
// Shared constants for the data_memory block-port arbiter: block geometry,
// default memory latency, FSM state encodings and the block-alignment helper.
package mem_block_arbiter_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int BLOCK_SIZE  = 16;
  localparam int MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // A block covers 16 consecutive word pointers, so the low nibble is dropped.
  function automatic logic [31:0] block_align(input logic [31:0] addr);
    return {addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/mem_block_arbiter_rr.sv
// Combinational grant selection from the request vector and rotating pointer.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, pointer ignored).
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               gnt_vld,
  output logic [PTR_W-1:0]   gnt_idx
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[PTR_W'(i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
  end
`else
  // Scan from the farthest offset down so the nearest set request at or after rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[PTR_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_block_arbiter.sv
// Shares the single data_memory block port between NUM_REQ cache requesters with a
// fixed access latency. Optional macro MEM_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module mem_block_arbiter
  import mem_block_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int LATENCY = MEM_LATENCY,
  parameter int BLOCK_W = BLOCK_SIZE * WORD_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [BLOCK_W-1:0]         rdata,
  output logic                       busy,
  output logic [31:0]                mem_ptr,
  output logic [BLOCK_W-1:0]         mem_in_block,
  output logic                       mem_we,
  input  logic [BLOCK_W-1:0]         mem_out_block
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_e       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] g_lat;
  logic             gnt_vld;
  logic             we_lat;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      addr_arr  [NUM_REQ];
  logic [BLOCK_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[32*i +: 32];
    assign wdata_arr[i] = req_wdata[BLOCK_W*i +: BLOCK_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    return (g == PTR_W'(NUM_REQ - 1)) ? '0 : g + PTR_W'(1);
  endfunction

  // mem_we is registered one cycle ahead so it is high during exactly the final BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      ack          <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      mem_ptr      <= '0;
      mem_in_block <= '0;
      cnt          <= '0;
      g_lat        <= '0;
      we_lat       <= 1'b0;
    end else begin
      ack    <= '0;
      mem_we <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gnt_vld) begin
            g_lat        <= gnt_idx;
            we_lat       <= req_we[gnt_idx];
            mem_ptr      <= block_align(addr_arr[gnt_idx]);
            mem_in_block <= wdata_arr[gnt_idx];
            cnt          <= CNT_LOAD;
            busy         <= 1'b1;
            mem_we       <= (LATENCY == 1) && req_we[gnt_idx];
            state        <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (cnt != '0) begin
            cnt    <= cnt - CNT_W'(1);
            mem_we <= (cnt == CNT_W'(1)) && we_lat;
          end else begin
            if (!we_lat) begin
              rdata <= mem_out_block;
            end
            ack   <= NUM_REQ'(1) << g_lat;
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          rr_ptr <= '0;
`else
          rr_ptr <= next_ptr(g_lat);
`endif
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
